// File: rtl/imem_boot_controller_if.sv
// Loader stream and instruction-memory port bundle for imem_boot_controller.
// The slave modport is the controller's view; the master modport is the
// loader/memory side (the testbench drives it directly).
interface imem_boot_controller_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              load_Valid;
  logic [DATA_W-1:0] load_Data;
  logic              load_Last;
  logic              load_Ready;
  logic              imem_Wr_En;
  logic [ADDR_W-1:0] imem_Wr_Addr;
  logic [DATA_W-1:0] imem_Wr_Data;
  logic [ADDR_W-1:0] imem_Rd_Addr;

  modport slave (
    input  load_Valid, load_Data, load_Last,
    output load_Ready, imem_Wr_En, imem_Wr_Addr, imem_Wr_Data, imem_Rd_Addr
  );

  modport master (
    output load_Valid, load_Data, load_Last,
    input  load_Ready, imem_Wr_En, imem_Wr_Addr, imem_Wr_Data, imem_Rd_Addr
  );
endinterface

// File: rtl/imem_boot_controller.sv
// Boot sequencer for the 32-word instruction memory: zero-fill, program
// load over a valid/ready stream, release of the CPU, fetch-address
// checking and reload handling. All memory write outputs are registered;
// the read index is a pure decode of the PC byte address.
module imem_boot_controller #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_boot_controller_if.slave bus,
  input  logic                 reload_Req,
  input  logic [31:0]          pc_Addr,
  output logic                 cpu_Stall,
  output logic                 fetch_Fault,
  output logic [ADDR_W:0]      word_Count
);

  typedef enum logic [2:0] {CLEAR, LOAD, DRAIN, RUN, FAULT} state_t;

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CLEAR_END = (ADDR_W+1)'(DEPTH);

  state_t              state;
  // One bit wider than the index so the value DEPTH marks "fill complete"
  // and the LOAD hand-off lands one cycle after the last zero write.
  logic [ADDR_W:0]     clr_idx;
  logic                ready_r;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [DATA_W-1:0]   wr_data_r;
  logic                handshake;
  logic                illegal;

  assign handshake = bus.load_Valid & ready_r;
  // Word-aligned and inside the 128-byte window, otherwise the fetch is illegal.
  assign illegal   = (pc_Addr[1:0] != 2'b00) || (pc_Addr[31:7] != 25'd0);

  assign bus.load_Ready   = ready_r;
  assign bus.imem_Wr_En   = wr_en_r;
  assign bus.imem_Wr_Addr = wr_addr_r;
  assign bus.imem_Wr_Data = wr_data_r;
  assign bus.imem_Rd_Addr = pc_Addr[ADDR_W+1:2];

  // Boot FSM with registered outputs; reset returns to CLEAR from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      ready_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      cpu_Stall   <= 1'b1;
      fetch_Fault <= 1'b0;
      word_Count  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == CLEAR_END) begin
            wr_en_r <= 1'b0;
            ready_r <= 1'b1;
            clr_idx <= '0;
            state   <= LOAD;
          end else begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= clr_idx[ADDR_W-1:0];
            wr_data_r <= '0;
            clr_idx   <= clr_idx + 1'b1;
          end
        end
        LOAD: begin
          wr_en_r <= handshake;
          if (handshake) begin
            wr_addr_r  <= word_Count[ADDR_W-1:0];
            wr_data_r  <= bus.load_Data;
            word_Count <= word_Count + 1'b1;
            // A full memory ends the program even without a Last marker.
            if (bus.load_Last || (word_Count == LAST_WORD)) begin
              ready_r <= 1'b0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          wr_en_r   <= 1'b0;
          cpu_Stall <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          wr_en_r <= 1'b0;
          // Reload takes priority over a simultaneous illegal fetch.
          if (reload_Req) begin
            cpu_Stall  <= 1'b1;
            word_Count <= '0;
            clr_idx    <= '0;
            state      <= CLEAR;
          end else if (illegal) begin
            cpu_Stall   <= 1'b1;
            fetch_Fault <= 1'b1;
            state       <= FAULT;
          end
        end
        FAULT: begin
          wr_en_r <= 1'b0;
          if (reload_Req) begin
            fetch_Fault <= 1'b0;
            word_Count  <= '0;
            clr_idx     <= '0;
            state       <= CLEAR;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_controller.sv
// Testbench for imem_boot_controller: scenario tasks with inline checks and
// a memory-image reference model built from the boot rules.
`timescale 1ns/1ps
module tb_imem_boot_controller;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              reload_Req = 1'b0;
  logic [31:0]       pc_Addr = 32'd0;
  logic              cpu_Stall;
  logic              fetch_Fault;
  logic [ADDR_W:0]   word_Count;

  imem_boot_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  imem_boot_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .reload_Req (reload_Req),
    .pc_Addr    (pc_Addr),
    .cpu_Stall  (cpu_Stall),
    .fetch_Fault(fetch_Fault),
    .word_Count (word_Count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory image seen on the write port, and the image the boot rules predict.
  logic [DATA_W-1:0] shadow  [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always @(negedge clk) begin
    if (bus.imem_Wr_En === 1'b1) shadow[bus.imem_Wr_Addr] <= bus.imem_Wr_Data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32 consecutive zero writes at indices 0..31, then LOAD with ready high.
  task automatic test_zero_fill();
    int w = 0;
    while (bus.imem_Wr_En !== 1'b1 && w < 4) begin
      tick();
      w++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bus.imem_Wr_En !== 1'b1 || bus.imem_Wr_Addr !== ADDR_W'(i) ||
          bus.imem_Wr_Data !== '0 || cpu_Stall !== 1'b1 ||
          bus.load_Ready !== 1'b0 || word_Count !== '0) begin
        bad++;
        $display("FAIL clear_write[%0d] en=%b addr=%0d data=%0h stall=%b rdy=%b cnt=%0d exp en=1 addr=%0d data=0 stall=1 rdy=0 cnt=0",
                 i, bus.imem_Wr_En, bus.imem_Wr_Addr, bus.imem_Wr_Data, cpu_Stall,
                 bus.load_Ready, word_Count, i);
      end
      tick();
    end
    total++;
    if (bus.load_Ready !== 1'b1 || bus.imem_Wr_En !== 1'b0 || cpu_Stall !== 1'b1) begin
      bad++;
      $display("FAIL clear_to_load rdy=%b en=%b stall=%b exp rdy=1 en=0 stall=1",
               bus.load_Ready, bus.imem_Wr_En, cpu_Stall);
    end
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
  endtask

  task automatic test_shadow(input string name);
    int diffs = 0;
    for (int k = 0; k < DEPTH; k++) if (shadow[k] !== ref_mem[k]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++;
      $display("FAIL %s mem_image differing_words=%0d exp 0", name, diffs);
    end
  endtask

  task automatic test_reset();
    bus.load_Valid = 1'b0;
    bus.load_Data  = '0;
    bus.load_Last  = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.load_Ready !== 1'b0 || bus.imem_Wr_En !== 1'b0 || bus.imem_Wr_Addr !== '0 ||
        bus.imem_Wr_Data !== '0 || cpu_Stall !== 1'b1 || fetch_Fault !== 1'b0 ||
        word_Count !== '0) begin
      bad++;
      $display("FAIL reset_values rdy=%b en=%b addr=%0d data=%0h stall=%b fault=%b cnt=%0d",
               bus.load_Ready, bus.imem_Wr_En, bus.imem_Wr_Addr, bus.imem_Wr_Data,
               cpu_Stall, fetch_Fault, word_Count);
    end
    rst = 1'b1;
    test_zero_fill();
  endtask

  task automatic test_reload_ignored();
    reload_Req = 1'b1;
    tick();
    reload_Req = 1'b0;
    total++;
    if (bus.load_Ready !== 1'b1 || bus.imem_Wr_En !== 1'b0 || cpu_Stall !== 1'b1) begin
      bad++;
      $display("FAIL reload_in_load rdy=%b en=%b stall=%b exp rdy=1 en=0 stall=1",
               bus.load_Ready, bus.imem_Wr_En, cpu_Stall);
    end
  endtask

  task automatic test_load_gaps();
    logic [DATA_W-1:0] words [3];
    words[0] = 32'h20010064;
    words[1] = 32'h20020001;
    words[2] = 32'h00411820;
    for (int i = 0; i < 3; i++) begin
      bus.load_Valid = 1'b1;
      bus.load_Data  = words[i];
      bus.load_Last  = (i == 2);
      tick();
      bus.load_Valid = 1'b0;
      bus.load_Last  = 1'b0;
      ref_mem[i] = words[i];
      total++;
      if (bus.imem_Wr_En !== 1'b1 || bus.imem_Wr_Addr !== ADDR_W'(i) ||
          bus.imem_Wr_Data !== words[i] || word_Count !== (ADDR_W+1)'(i + 1)) begin
        bad++;
        $display("FAIL gap_write[%0d] en=%b addr=%0d data=%0h cnt=%0d exp en=1 addr=%0d data=%0h cnt=%0d",
                 i, bus.imem_Wr_En, bus.imem_Wr_Addr, bus.imem_Wr_Data, word_Count,
                 i, words[i], i + 1);
      end
      if (i < 2) begin
        repeat (2) begin
          tick();
          total++;
          if (bus.imem_Wr_En !== 1'b0) begin
            bad++;
            $display("FAIL gap_idle en=%b exp 0", bus.imem_Wr_En);
          end
        end
      end
    end
    total++;
    if (bus.load_Ready !== 1'b0 || cpu_Stall !== 1'b1) begin
      bad++;
      $display("FAIL drain_cycle rdy=%b stall=%b exp rdy=0 stall=1", bus.load_Ready, cpu_Stall);
    end
    tick();
    total++;
    if (cpu_Stall !== 1'b0 || bus.imem_Wr_En !== 1'b0 || word_Count !== 6'd3) begin
      bad++;
      $display("FAIL run_entry stall=%b en=%b cnt=%0d exp stall=0 en=0 cnt=3",
               cpu_Stall, bus.imem_Wr_En, word_Count);
    end
    test_shadow("gap_load");
  endtask

  task automatic test_fetch();
    int idx;
    pc_Addr = 32'h8;
    #1;
    total++;
    if (bus.imem_Rd_Addr !== 5'd2) begin
      bad++;
      $display("FAIL rd_addr_8 got=%0d exp 2", bus.imem_Rd_Addr);
    end
    for (int r = 0; r < 6; r++) begin
      idx = $urandom_range(0, DEPTH - 1);
      pc_Addr = 32'(idx * 4);
      #1;
      total++;
      if (bus.imem_Rd_Addr !== ADDR_W'(idx)) begin
        bad++;
        $display("FAIL rd_addr_rand pc=%0h got=%0d exp %0d", pc_Addr, bus.imem_Rd_Addr, idx);
      end
      tick();
      total++;
      if (fetch_Fault !== 1'b0 || cpu_Stall !== 1'b0) begin
        bad++;
        $display("FAIL legal_fetch pc=%0h fault=%b stall=%b exp 0 0", pc_Addr, fetch_Fault, cpu_Stall);
      end
    end
    pc_Addr = 32'h6;
    tick();
    total++;
    if (fetch_Fault !== 1'b1 || cpu_Stall !== 1'b1 || bus.imem_Rd_Addr !== 5'd1) begin
      bad++;
      $display("FAIL misaligned_fault fault=%b stall=%b rd=%0d exp 1 1 1",
               fetch_Fault, cpu_Stall, bus.imem_Rd_Addr);
    end
    pc_Addr = 32'h8;
    repeat (2) tick();
    total++;
    if (fetch_Fault !== 1'b1 || cpu_Stall !== 1'b1) begin
      bad++;
      $display("FAIL fault_sticky fault=%b stall=%b exp 1 1", fetch_Fault, cpu_Stall);
    end
  endtask

  task automatic test_reload_from_fault();
    reload_Req = 1'b1;
    tick();
    reload_Req = 1'b0;
    pc_Addr = 32'h0;
    total++;
    if (fetch_Fault !== 1'b0 || word_Count !== '0 || cpu_Stall !== 1'b1) begin
      bad++;
      $display("FAIL reload_fault fault=%b cnt=%0d stall=%b exp 0 0 1",
               fetch_Fault, word_Count, cpu_Stall);
    end
    test_zero_fill();
  endtask

  // Streams n words with random gaps; Last only on the n-th when use_last.
  task automatic test_stream(input string name, input int n, input bit use_last, input bit gaps);
    logic [DATA_W-1:0] words [33];
    int sent = 0;
    int writes = 0;
    int cyc = 0;
    bit hs;
    for (int k = 0; k < n; k++) words[k] = $urandom;
    while (cyc < 200 && !(writes >= n && cyc > 2 * n + 6) && !(writes >= DEPTH && cyc > 40)) begin
      bus.load_Valid = (sent < n) && (!gaps || $urandom_range(0, 2) != 0);
      bus.load_Data  = (sent < n) ? words[sent] : '0;
      bus.load_Last  = use_last && (sent == n - 1);
      hs = (bus.load_Ready === 1'b1) && bus.load_Valid;
      tick();
      if (hs) sent++;
      if (bus.imem_Wr_En === 1'b1) begin
        total++;
        if (writes >= DEPTH || bus.imem_Wr_Addr !== ADDR_W'(writes) ||
            bus.imem_Wr_Data !== words[writes]) begin
          bad++;
          $display("FAIL %s write[%0d] addr=%0d data=%0h exp addr=%0d", name, writes,
                   bus.imem_Wr_Addr, bus.imem_Wr_Data, writes);
        end
        if (writes < DEPTH) ref_mem[writes] = words[writes];
        writes++;
        if (writes > DEPTH) break;
      end
      cyc++;
    end
    bus.load_Valid = 1'b0;
    bus.load_Last  = 1'b0;
    total++;
    if (writes != ((n > DEPTH) ? DEPTH : n) || word_Count !== (ADDR_W+1)'((n > DEPTH) ? DEPTH : n)) begin
      bad++;
      $display("FAIL %s count writes=%0d cnt=%0d exp %0d", name, writes, word_Count,
               (n > DEPTH) ? DEPTH : n);
    end
    total++;
    if (bus.load_Ready !== 1'b0 || cpu_Stall !== 1'b0 || fetch_Fault !== 1'b0) begin
      bad++;
      $display("FAIL %s run_state rdy=%b stall=%b fault=%b exp 0 0 0", name,
               bus.load_Ready, cpu_Stall, fetch_Fault);
    end
    test_shadow(name);
  endtask

  task automatic test_fault_high();
    pc_Addr = 32'h80;
    tick();
    total++;
    if (fetch_Fault !== 1'b1 || cpu_Stall !== 1'b1) begin
      bad++;
      $display("FAIL high_addr_fault fault=%b stall=%b exp 1 1", fetch_Fault, cpu_Stall);
    end
    test_reload_from_fault();
  endtask

  task automatic test_collision();
    pc_Addr = 32'h6;
    reload_Req = 1'b1;
    tick();
    reload_Req = 1'b0;
    pc_Addr = 32'h0;
    total++;
    if (fetch_Fault !== 1'b0 || cpu_Stall !== 1'b1 || word_Count !== '0) begin
      bad++;
      $display("FAIL reload_vs_illegal fault=%b stall=%b cnt=%0d exp 0 1 0",
               fetch_Fault, cpu_Stall, word_Count);
    end
    test_zero_fill();
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 5; i++) begin
      bus.load_Valid = 1'b1;
      bus.load_Data  = $urandom;
      bus.load_Last  = 1'b0;
      tick();
    end
    bus.load_Valid = 1'b0;
    total++;
    if (word_Count !== 6'd5) begin
      bad++;
      $display("FAIL midload_count got=%0d exp 5", word_Count);
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (bus.load_Ready !== 1'b0 || bus.imem_Wr_En !== 1'b0 || bus.imem_Wr_Addr !== '0 ||
        bus.imem_Wr_Data !== '0 || cpu_Stall !== 1'b1 || fetch_Fault !== 1'b0 ||
        word_Count !== '0) begin
      bad++;
      $display("FAIL async_reset rdy=%b en=%b addr=%0d data=%0h stall=%b fault=%b cnt=%0d",
               bus.load_Ready, bus.imem_Wr_En, bus.imem_Wr_Addr, bus.imem_Wr_Data,
               cpu_Stall, fetch_Fault, word_Count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    test_zero_fill();
  endtask

  initial begin
    test_reset();
    test_reload_ignored();
    test_load_gaps();
    test_fetch();
    test_reload_from_fault();
    test_stream("overflow", 33, 1'b0, 1'b0);
    test_fault_high();
    for (int r = 0; r < 3; r++) begin
      test_stream("random_load", $urandom_range(1, DEPTH), 1'b1, 1'b1);
      test_collision();
    end
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_controller.md
Name: imem_boot_controller

Overview:
Sequences the single-cycle CPU's 32-word instruction memory through boot. After reset it zero-fills the memory, accepts a program from an external loader over a valid/ready stream, and then releases the CPU to fetch. In RUN it forms the instruction-memory read index from the PC, detects illegal fetch addresses, and services reload requests. It sits between the loader, the PC register and the instruction memory's write/read ports.

Parameters:
DEPTH, 32, number of instruction words in memory
ADDR_W, 5, word-index width (log2 DEPTH)
DATA_W, 32, instruction width

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
load_Valid  input  1  loader presents a word
load_Data  input  DATA_W  instruction word
load_Last  input  1  marks final word of program
load_Ready  output  1  controller accepts word this cycle
reload_Req  input  1  request re-clear and reload (single-cycle pulse or level)
pc_Addr  input  32  byte address from PC
imem_Wr_En  output  1  memory write strobe
imem_Wr_Addr  output  ADDR_W  memory write index
imem_Wr_Data  output  DATA_W  memory write data
imem_Rd_Addr  output  ADDR_W  memory read index
cpu_Stall  output  1  hold PC/CPU state
fetch_Fault  output  1  sticky illegal-fetch flag
word_Count  output  ADDR_W+1  words loaded in current program

Behaviour:
- States: CLEAR, LOAD, DRAIN, RUN, FAULT. Reset (rst low) forces CLEAR asynchronously from any state, including mid-load; on release, clearing restarts at index 0.
- Reset values: load_Ready 0, imem_Wr_En 0, imem_Wr_Addr 0, imem_Wr_Data 0, cpu_Stall 1, fetch_Fault 0, word_Count 0.
- All imem_Wr_* outputs are registered. imem_Rd_Addr = pc_Addr[6:2] combinationally in every state.
- CLEAR:
  - One write per cycle with data 0.
  - Index counter runs 0..DEPTH-1: the first edge after reset release produces imem_Wr_En=1 with Addr 0, continuing through Addr 31 (32 cycles).
  - After the Addr 31 write, go to LOAD.
- LOAD:
  - load_Ready=1.
  - A handshake (load_Valid & load_Ready) at edge N produces imem_Wr_En=1, Addr=word_Count, Data=load_Data in cycle N+1. word_Count increments at the same edge.
  - load_Valid low stalls without a write; gaps are allowed.
  - A handshake with load_Last=1, or the handshake of the DEPTH-th word (word_Count reaching 32) even without Last, goes to DRAIN and load_Ready drops the next cycle. Further words are never accepted.
- DRAIN:
  - Lasts one cycle.
  - The final write is on the bus during this cycle; next state is RUN.
- RUN:
  - cpu_Stall=0, load_Ready=0, imem_Wr_En=0.
  - Illegal fetch: pc_Addr[1:0]!=0 or pc_Addr[31:7]!=0, evaluated each cycle. It goes to FAULT at the next edge and sets fetch_Fault=1.
  - reload_Req=1 goes to CLEAR, clears word_Count to 0 and asserts cpu_Stall from the next cycle.
  - If reload_Req and an illegal fetch occur in the same cycle, reload wins and fetch_Fault stays 0.
- FAULT:
  - cpu_Stall=1, fetch_Fault=1 (sticky).
  - Exits only via reload_Req, which goes to CLEAR and clears fetch_Fault, or via reset.
- cpu_Stall is 1 in CLEAR, LOAD, DRAIN and FAULT.
- reload_Req is ignored in CLEAR, LOAD and DRAIN.
- A zero-word program is impossible: LOAD waits indefinitely for the first word.

Test Plan:
- Reset low 3 cycles, release -> 32 consecutive writes Addr 0..31 Data 0; load_Ready rises in cycle 33; cpu_Stall=1 throughout.
- Load 0x20010064, 0x20020001, 0x00411820 (Last on 3rd) with load_Valid gaps of 2 cycles -> writes at Addr 0,1,2 one cycle after each handshake; word_Count=3; cpu_Stall falls 2 cycles after the 3rd handshake.
- Stream 33 words with no Last -> exactly 32 writes (Addr 0..31); 33rd word not accepted (load_Ready=0); RUN entered.
- In RUN, pc_Addr 0x00000008 -> imem_Rd_Addr=2, no fault. Then pc_Addr 0x00000006 -> fetch_Fault=1 and cpu_Stall=1 next cycle. Then pc_Addr 0x00000080 after reload -> fault again.
- FAULT + reload_Req pulse -> fetch_Fault=0, word_Count=0, new 32-cycle zero-fill begins next cycle.
- Assert rst low after 5 words loaded -> all outputs to reset values immediately; on release clearing restarts at Addr 0 and word_Count=0.
